// File: rtl/grid_router_gcr_tx_sched.sv
// Transmit scheduler for one grid-router output link: arbitrates NPORT symbol sources,
// drives the registered GCR encoder and serialises its 8-bit code MSB-first.
// Define GRID_ROUTER_GCR_RR_EN for round-robin arbitration; otherwise fixed priority.
module grid_router_gcr_tx_sched #(
  parameter int         NPORT    = 4,
  parameter logic [5:0] IDLE_SYM = 6'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NPORT-1:0]   req_valid,
  input  logic [NPORT*6-1:0] req_data,
  input  logic [NPORT-1:0]   req_last,
  output logic [NPORT-1:0]   req_ready,
  output logic [NPORT-1:0]   grant,
  output logic [5:0]         enc_i,
  input  logic [7:0]         enc_o,
  output logic               tx_bit,
  output logic               tx_frame,
  output logic               busy
);

  localparam logic [NPORT-1:0] ONE       = NPORT'(1);
  localparam logic [7:0]       IDLE_CODE = 8'h96;

  logic [2:0]       bcnt;
  logic             slot;
  logic             locked;
  logic             tag_i;
  logic             tag_o;
  logic             tag_sh;
  logic [7:0]       shreg;
  logic [NPORT-1:0] win;
  logic [NPORT-1:0] xfer;
  logic             xfer_any;
  logic             xfer_last;
  logic [5:0]       xfer_data;

  function automatic logic [NPORT-1:0] lowest(input logic [NPORT-1:0] v);
    return v & (~v + ONE);
  endfunction

  assign slot = (bcnt == 3'd5);

`ifdef GRID_ROUTER_GCR_RR_EN
  logic [NPORT-1:0] above;

  // Ports numbered above the last owner; empty after reset (grant==0), so port 0 wins first.
  assign above = ~(grant | (grant - ONE));
  assign win   = ((req_valid & above) != '0) ? lowest(req_valid & above)
                                             : lowest(req_valid);
`else
  assign win = lowest(req_valid);
`endif

  assign req_ready = slot ? (locked ? grant : win) : '0;
  assign xfer      = req_ready & req_valid;
  assign xfer_any  = |xfer;

  // NOTE: defaults are assigned first so every path writes both outputs; no latch is inferred.
  always_comb begin
    xfer_data = IDLE_SYM;
    xfer_last = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (xfer[p]) begin
        xfer_data = req_data[6*p +: 6];
        xfer_last = req_last[p];
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt   <= 3'd0;
      locked <= 1'b0;
      grant  <= '0;
      enc_i  <= IDLE_SYM;
      tag_i  <= 1'b0;
      tag_o  <= 1'b0;
      tag_sh <= 1'b0;
      shreg  <= IDLE_CODE;
    end else begin
      bcnt  <= bcnt + 3'd1;
      tag_o <= tag_i;
      if (slot) begin
        enc_i <= xfer_data;
        tag_i <= xfer_any;
        if (xfer_any) begin
          grant  <= xfer;
          locked <= ~xfer_last;
        end
      end
      // enc_o reflects the enc_i written two cycles earlier, so bcnt==7 loads the slot's code.
      if (bcnt == 3'd7) begin
        shreg  <= enc_o;
        tag_sh <= tag_o;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  assign tx_bit   = shreg[7];
  assign tx_frame = tag_sh;
  assign busy     = locked | tag_i | tag_o | tag_sh;

endmodule
